// File: rtl/fifo.sv
// Single-frame ingress buffer: stores one AXI-Stream frame, then drains it word by word or discards it.
// Occupancy is exported for the filter/parser; storage maps onto a simple dual-port block RAM.
module fifo #(
    parameter int C_s_axis_rxd_TDATA_WIDTH = 32,
    parameter int fifo_depth               = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_rxd_tvalid,
    input  logic                                i_rxd_tlast,
    input  logic [C_s_axis_rxd_TDATA_WIDTH-1:0] i_rx_data,
    output logic                                o_rxd_tready,
    input  logic                                i_rd_valid,
    input  logic                                i_fifo_invalid,
    output logic [C_s_axis_rxd_TDATA_WIDTH-1:0] o_data,
    output logic [fifo_depth-1:0]               o_wr_cnt
);

    localparam int MEM_WORDS = 2 ** fifo_depth;
    localparam logic [fifo_depth-1:0] CNT_ONE  = {{(fifo_depth-1){1'b0}}, 1'b1};
    localparam logic [fifo_depth-1:0] CNT_FULL = {fifo_depth{1'b1}};
    localparam logic [fifo_depth-1:0] CNT_ZERO = {fifo_depth{1'b0}};

    logic [C_s_axis_rxd_TDATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];
    logic [C_s_axis_rxd_TDATA_WIDTH-1:0] data_r;
    logic [fifo_depth-1:0]               wr_ptr_r;
    logic [fifo_depth-1:0]               rd_ptr_r;
    logic [fifo_depth-1:0]               cnt_r;
    logic                                frame_lock_r;

    logic [fifo_depth-1:0]               wr_ptr_s;
    logic [fifo_depth-1:0]               rd_ptr_s;
    logic [fifo_depth-1:0]               cnt_s;
    logic                                frame_lock_s;
    logic                                full_s;
    logic                                empty_s;
    logic                                tready_s;
    logic                                wr_en_s;
    logic                                rd_en_s;

    assign full_s   = (cnt_r == CNT_FULL);
    assign empty_s  = (cnt_r == CNT_ZERO);
    // Flush blocks the write handshake directly, so a dropped beat is never acknowledged.
    assign tready_s = !rst && !full_s && !frame_lock_r && !i_fifo_invalid;
    assign wr_en_s  = i_rxd_tvalid && tready_s;
    assign rd_en_s  = i_rd_valid && !empty_s && !i_fifo_invalid;

    assign o_rxd_tready = tready_s;
    assign o_data       = data_r;
    assign o_wr_cnt     = cnt_r;

    // Next-state for pointers, occupancy and frame lock; flush overrides everything.
    always_comb begin
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        cnt_s        = cnt_r;
        frame_lock_s = frame_lock_r;
        if (i_fifo_invalid) begin
            wr_ptr_s     = CNT_ZERO;
            rd_ptr_s     = CNT_ZERO;
            cnt_s        = CNT_ZERO;
            frame_lock_s = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_s = wr_ptr_r + CNT_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_s = rd_ptr_r + CNT_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   cnt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_s = cnt_r - CNT_ONE;
                default: cnt_s = cnt_r;
            endcase
            // Lock releases only when the last resident word leaves.
            if (wr_en_s && i_rxd_tlast) begin
                frame_lock_s = 1'b1;
            end else if (rd_en_s && !wr_en_s && (cnt_r == CNT_ONE)) begin
                frame_lock_s = 1'b0;
            end else begin
                frame_lock_s = frame_lock_r;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= CNT_ZERO;
            rd_ptr_r     <= CNT_ZERO;
            cnt_r        <= CNT_ZERO;
            frame_lock_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            cnt_r        <= cnt_s;
            frame_lock_r <= frame_lock_s;
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_rx_data;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {C_s_axis_rxd_TDATA_WIDTH{1'b0}};
        end else if (rd_en_s) begin
            data_r <= mem_r[rd_ptr_r];
        end else begin
            data_r <= data_r;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the ingress frame FIFO: a vector table for basic behaviour plus
// hand-written sequences for reset, frame lock, flush, full and pointer wrap.
module tb_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rxd_tvalid = 1'b0;
    logic        i_rxd_tlast = 1'b0;
    logic [31:0] i_rx_data = 32'h0;
    logic        o_rxd_tready;
    logic        i_rd_valid = 1'b0;
    logic        i_fifo_invalid = 1'b0;
    logic [31:0] o_data;
    logic [8:0]  o_wr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_q [$];
    logic [31:0] exp_word;

    typedef struct packed {
        logic        tv;
        logic        tl;
        logic [31:0] d;
        logic        rd;
        logic        inv;
        logic [31:0] exp_data;
        logic [8:0]  exp_cnt;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs [0:11];

    fifo #(
        .C_s_axis_rxd_TDATA_WIDTH(32),
        .fifo_depth(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_rxd_tvalid(i_rxd_tvalid),
        .i_rxd_tlast(i_rxd_tlast),
        .i_rx_data(i_rx_data),
        .o_rxd_tready(o_rxd_tready),
        .i_rd_valid(i_rd_valid),
        .i_fifo_invalid(i_fifo_invalid),
        .o_data(o_data),
        .o_wr_cnt(o_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic drive(input logic tv, input logic tl, input logic [31:0] d,
                         input logic rd, input logic inv);
        i_rxd_tvalid   = tv;
        i_rxd_tlast    = tl;
        i_rx_data      = d;
        i_rd_valid     = rd;
        i_fifo_invalid = inv;
        @(negedge clk);
    endtask

    initial begin
        //              tv    tl    data        rd    inv   exp_data    cnt    rdy
        vecs[0]  = '{1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 32'h00, 9'd1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 32'h00, 9'd2, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 32'h00, 9'd3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 32'h11, 9'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 32'h22, 9'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h33, 9'd0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h33, 9'd0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h66, 1'b1, 1'b0, 32'h33, 9'd1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 32'h66, 9'd1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h88, 1'b1, 1'b1, 32'h66, 9'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 32'h66, 9'd1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h99, 9'd0, 1'b1};

        // Power-on reset state.
        @(negedge clk);
        @(negedge clk);
        check("por_cnt", {23'd0, o_wr_cnt}, 32'd0);
        check("por_data", o_data, 32'd0);
        check("por_rdy", {31'd0, o_rxd_tready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", {31'd0, o_rxd_tready}, 32'd1);
        check("post_rst_cnt", {23'd0, o_wr_cnt}, 32'd0);

        // Vector table.
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].tv, vecs[v].tl, vecs[v].d, vecs[v].rd, vecs[v].inv);
            check($sformatf("vec%0d_data", v), o_data, vecs[v].exp_data);
            check($sformatf("vec%0d_cnt", v), {23'd0, o_wr_cnt}, {23'd0, vecs[v].exp_cnt});
            check($sformatf("vec%0d_rdy", v), {31'd0, o_rxd_tready}, {31'd0, vecs[v].exp_rdy});
        end
        i_rd_valid = 1'b0;

        // Mid-run asynchronous reset: outputs clear before any rising edge.
        drive(1'b1, 1'b0, 32'hCAFE0001, 1'b0, 1'b0);
        check("pre_rst_cnt", {23'd0, o_wr_cnt}, 32'd1);
        i_rxd_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_cnt", {23'd0, o_wr_cnt}, 32'd0);
        check("async_rst_data", o_data, 32'd0);
        check("async_rst_rdy", {31'd0, o_rxd_tready}, 32'd0);
        #9;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_rdy", {31'd0, o_rxd_tready}, 32'd1);

        // One 16-beat frame, then extra beats that must be refused.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i == 15), 32'(i + 1), 1'b0, 1'b0);
        end
        check("frame_cnt", {23'd0, o_wr_cnt}, 32'd16);
        check("frame_lock_rdy", {31'd0, o_rxd_tready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hDEAD0000 + 32'(i), 1'b0, 1'b0);
            check("locked_cnt", {23'd0, o_wr_cnt}, 32'd16);
        end

        // Drain the frame, one cycle read latency.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("drain%0d_data", i), o_data, 32'(i + 1));
            check($sformatf("drain%0d_cnt", i), {23'd0, o_wr_cnt}, 32'(15 - i));
        end
        check("drain_rdy", {31'd0, o_rxd_tready}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("empty_read_hold", o_data, 32'd16);

        // Partial frame discarded by a one-cycle flush.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h55000000 + 32'(i), 1'b0, 1'b0);
        end
        check("partial_cnt", {23'd0, o_wr_cnt}, 32'd8);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("flush_cnt", {23'd0, o_wr_cnt}, 32'd0);
        check("flush_data_hold", o_data, 32'd16);
        check("flush_rdy", {31'd0, o_rxd_tready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 3), 32'hAABBCC01 + 32'(i), 1'b0, 1'b0);
        end
        check("new_frame_cnt", {23'd0, o_wr_cnt}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("new_frame%0d", i), o_data, 32'hAABBCC01 + 32'(i));
        end
        check("new_frame_empty", {23'd0, o_wr_cnt}, 32'd0);

        // Fill to capacity; surplus beats dropped.
        for (int i = 0; i < 520; i++) begin
            drive(1'b1, 1'b0, 32'h00010000 + 32'(i), 1'b0, 1'b0);
            if (i < 511) model_q.push_back(32'h00010000 + 32'(i));
        end
        check("full_cnt", {23'd0, o_wr_cnt}, 32'd511);
        check("full_rdy", {31'd0, o_rxd_tready}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        exp_word = model_q.pop_front();
        check("full_read_data", o_data, exp_word);
        check("full_read_cnt", {23'd0, o_wr_cnt}, 32'd510);
        check("full_read_rdy", {31'd0, o_rxd_tready}, 32'd1);

        // Read down to five words, crossing the pointer wrap.
        for (int i = 0; i < 505; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            exp_word = model_q.pop_front();
            check($sformatf("wrap_rd%0d", i), o_data, exp_word);
            check($sformatf("wrap_cnt%0d", i), {23'd0, o_wr_cnt}, 32'(509 - i));
        end

        // Simultaneous write and read hold the count.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h00020000 + 32'(i), 1'b1, 1'b0);
            exp_word = model_q.pop_front();
            model_q.push_back(32'h00020000 + 32'(i));
            check($sformatf("simul%0d_data", i), o_data, exp_word);
            check($sformatf("simul%0d_cnt", i), {23'd0, o_wr_cnt}, 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            exp_word = model_q.pop_front();
            check($sformatf("tail%0d_data", i), o_data, exp_word);
            check($sformatf("tail%0d_cnt", i), {23'd0, o_wr_cnt}, 32'(4 - i));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
